// File: rtl/i2s_source_controller_if.sv
// I2S source controller pin bundle.
// LE/button/strap inputs and select/mute/status outputs.
`timescale 1ns/1ps
interface i2s_source_controller_if;
  logic       in_le_1;
  logic       in_le_2;
  logic       in_button;
  logic       in_auto_enable;
  logic       out_select;
  logic       out_mute;
  logic       out_active_1;
  logic       out_active_2;
  logic [2:0] out_state;

  modport master (
    output in_le_1,
    output in_le_2,
    output in_button,
    output in_auto_enable,
    input  out_select,
    input  out_mute,
    input  out_active_1,
    input  out_active_2,
    input  out_state
  );

  modport slave (
    input  in_le_1,
    input  in_le_2,
    input  in_button,
    input  in_auto_enable,
    output out_select,
    output out_mute,
    output out_active_1,
    output out_active_2,
    output out_state
  );
endinterface

// File: rtl/i2s_source_controller.sv
// Two-input I2S source sequencer: debounced button,
// LE activity detection, frame-aligned muted switching.
`timescale 1ns/1ps
module i2s_source_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LOCKOUT_CYCLES  = 50000000,
  parameter int ACTIVITY_WINDOW = 500000,
  parameter int MIN_EDGES       = 16,
  parameter int MUTE_FRAMES     = 4,
  parameter int FRAME_TIMEOUT   = 65536
) (
  input  logic in_clk,
  input  logic in_reset,
  i2s_source_controller_if.slave bus
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LKW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int WNW = $clog2(ACTIVITY_WINDOW + 1);
  localparam int EGW = $clog2(MIN_EDGES + 1);
  localparam int FRW = $clog2(MUTE_FRAMES + 1);
  localparam int TOW = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LKW-1:0] LK_LAST =
    LKW'(LOCKOUT_CYCLES - 1);
  localparam logic [WNW-1:0] WN_LAST =
    WNW'(ACTIVITY_WINDOW - 1);
  localparam logic [EGW-1:0] EG_MIN =
    EGW'(MIN_EDGES);
  localparam logic [FRW-1:0] FR_LAST =
    FRW'(MUTE_FRAMES - 1);
  localparam logic [TOW-1:0] TO_LAST =
    TOW'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RUN       = 3'd0,
    S_MUTE_PRE  = 3'd1,
    S_SWITCH    = 3'd2,
    S_MUTE_POST = 3'd3,
    S_LOCKOUT   = 3'd4
  } state_t;

  logic [3:0]     w_raw;
  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [1:0]     r_le_d;
  logic [1:0]     r_le_rise;
  logic           w_btn;
  logic           w_auto;
  logic           r_db_level;
  logic [DBW-1:0] r_db_cnt;
  logic           r_press;
  logic [WNW-1:0] r_win_cnt;
  logic           w_wrap;
  logic [EGW-1:0] r_edge [2];
  logic [1:0]     r_active;
  state_t         r_state;
  logic           r_select;
  logic           r_mute;
  logic [FRW-1:0] r_frame_cnt;
  logic [TOW-1:0] r_to_cnt;
  logic [LKW-1:0] r_lock_cnt;
  logic           w_frame_edge;
  logic           w_tick;
  logic           w_done;
  logic           w_act_sel;
  logic           w_act_oth;
  logic           w_req;

  assign w_raw = {bus.in_auto_enable, bus.in_button,
                  bus.in_le_2, bus.in_le_1};
  assign w_btn  = r_sync2[2];
  assign w_auto = r_sync2[3];

  // Two-flop synchronisers for all asynchronous inputs
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Registered LE rising-edge pulses
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_le_d    <= '0;
      r_le_rise <= '0;
    end else begin
      r_le_d    <= r_sync2[1:0];
      r_le_rise <= r_sync2[1:0] & ~r_le_d;
    end
  end

  // Button debounce; press pulse on debounced rise only
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_btn != r_db_level) begin
        if (r_db_cnt >= DB_LAST) begin
          r_db_level <= w_btn;
          r_db_cnt   <= '0;
          r_press    <= w_btn;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_wrap = (r_win_cnt >= WN_LAST);

  // Windowed LE edge counting and activity flags
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_win_cnt <= '0;
      r_active  <= '0;
      r_edge[0] <= '0;
      r_edge[1] <= '0;
    end else begin
      r_win_cnt <= w_wrap ? '0 : r_win_cnt + 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (w_wrap) begin
          r_active[i] <= (r_edge[i] >= EG_MIN);
          r_edge[i]   <= r_le_rise[i] ? EGW'(1) : '0;
        end else if (r_le_rise[i] &&
                     (r_edge[i] < EG_MIN)) begin
          r_edge[i] <= r_edge[i] + 1'b1;
        end
      end
    end
  end

  assign w_frame_edge = r_select ? r_le_rise[1]
                                 : r_le_rise[0];
  assign w_tick = w_frame_edge |
                  (r_to_cnt >= TO_LAST);
  assign w_done = w_tick & (r_frame_cnt >= FR_LAST);

  assign w_act_sel = r_select ? r_active[1]
                              : r_active[0];
  assign w_act_oth = r_select ? r_active[0]
                              : r_active[1];
  assign w_req = r_press |
                 (w_auto & ~w_act_sel & w_act_oth);

  // Switch sequencer with registered select/mute
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      r_state     <= S_MUTE_POST;
      r_select    <= 1'b0;
      r_mute      <= 1'b1;
      r_frame_cnt <= '0;
      r_to_cnt    <= '0;
      r_lock_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          r_mute <= 1'b0;
          if (w_req) begin
            r_state     <= S_MUTE_PRE;
            r_mute      <= 1'b1;
            r_frame_cnt <= '0;
            r_to_cnt    <= '0;
          end
        end
        S_MUTE_PRE: begin
          r_mute <= 1'b1;
          if (w_done) begin
            r_state <= S_SWITCH;
          end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_to_cnt    <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_SWITCH: begin
          r_mute      <= 1'b1;
          r_select    <= ~r_select;
          r_frame_cnt <= '0;
          r_to_cnt    <= '0;
          r_state     <= S_MUTE_POST;
        end
        S_MUTE_POST: begin
          if (w_done) begin
            r_state    <= S_LOCKOUT;
            r_mute     <= 1'b0;
            r_lock_cnt <= '0;
          end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_to_cnt    <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_LOCKOUT: begin
          r_mute <= 1'b0;
          if (r_lock_cnt >= LK_LAST) begin
            r_state <= S_RUN;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= S_MUTE_POST;
          r_mute      <= 1'b1;
          r_frame_cnt <= '0;
          r_to_cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.out_select   = r_select;
  assign bus.out_mute     = r_mute;
  assign bus.out_active_1 = r_active[0];
  assign bus.out_active_2 = r_active[1];
  assign bus.out_state    = r_state;

endmodule
